writeback_buffer: RTL and testbench

Buffers dirty/evicted blocks between the 2-way set-associative cache and main memory, so the cache never waits for a memory write.
- Accepts evictions (tag, set, 16-bit block) from the cache in one cycle.
- Drains them in FIFO order to main memory over a valid/ready write port.
- Provides a combinational lookup port so a cache miss fill can take a block still pending in the buffer instead of stale main-memory data.
- Supports a flush command that empties the buffer and then reports completion.

---
 rtl/writeback_buffer.sv | 164 ++++++++++++++++
 tb/tb_writeback_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_buffer.sv
// Purpose: eviction write-back buffer between the 2-way cache and main memory, with miss-fill lookup and flush.
// Latency: a push into an empty buffer presents mem_wr_valid the next cycle; lookup is combinational.
// Backpressure: evict_ready drops when full or flushing; the head holds while mem_wr_ready is low.
// Optional: define WB_COALESCE_EN to merge a push into a matching non-head entry instead of allocating.
module writeback_buffer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 3,
    parameter int SET_W   = 3,
    parameter int BLOCK_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         evict_valid,
    output logic                         evict_ready,
    input  logic [TAG_W-1:0]             evict_tag,
    input  logic [SET_W-1:0]             evict_set,
    input  logic [BLOCK_W-1:0]           evict_block,
    output logic                         mem_wr_valid,
    input  logic                         mem_wr_ready,
    output logic [TAG_W-1:0]             mem_wr_tag,
    output logic [SET_W-1:0]             mem_wr_set,
    output logic [BLOCK_W-1:0]           mem_wr_block,
    input  logic [TAG_W-1:0]             lookup_tag,
    input  logic [SET_W-1:0]             lookup_set,
    output logic                         lookup_hit,
    output logic [BLOCK_W-1:0]           lookup_block,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DONE} state_t;

    state_t             state_q;
    logic               flush_done_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, empty_q;
    logic [DEPTH-1:0]   vld_q;
    logic [TAG_W-1:0]   tag_q [DEPTH];
    logic [SET_W-1:0]   set_q [DEPTH];
    logic [BLOCK_W-1:0] blk_q [DEPTH];

    logic push_req, push_alloc, pop;
    logic coal_hit;

`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] coal_idx;

    // Find a valid entry behind the head with the same tag/set; the head itself is never merged into.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (vld_q[rd_ptr_q + PTR_W'(k)] &&
                tag_q[rd_ptr_q + PTR_W'(k)] == evict_tag &&
                set_q[rd_ptr_q + PTR_W'(k)] == evict_set) begin
                coal_hit = 1'b1;
                coal_idx = rd_ptr_q + PTR_W'(k);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    // Handshakes: full buffer refuses allocation even if the head pops this cycle.
    assign evict_ready  = (state_q == S_IDLE) && (!full_q || coal_hit);
    assign push_req     = evict_valid && evict_ready;
    assign push_alloc   = push_req && !coal_hit;
    assign mem_wr_valid = !empty_q;
    assign pop          = mem_wr_valid && mem_wr_ready;
    assign count_d      = count_q + CNT_W'(push_alloc) - CNT_W'(pop);

    assign mem_wr_tag   = tag_q[rd_ptr_q];
    assign mem_wr_set   = set_q[rd_ptr_q];
    assign mem_wr_block = blk_q[rd_ptr_q];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign flush_done   = flush_done_q;

    // Lookup walks oldest to youngest so the last match (youngest duplicate) wins.
    always_comb begin
        lookup_hit   = 1'b0;
        lookup_block = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_q[rd_ptr_q + PTR_W'(k)] &&
                tag_q[rd_ptr_q + PTR_W'(k)] == lookup_tag &&
                set_q[rd_ptr_q + PTR_W'(k)] == lookup_set) begin
                lookup_hit   = 1'b1;
                lookup_block = blk_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    // Flush sequencer: block pushes, wait for the last pop, then pulse flush_done for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_req) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (empty_q || (pop && count_q == CNT_W'(1))) begin
                        state_q      <= S_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Circular storage, pointers and occupancy; in-flight writes are dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                set_q[i] <= '0;
                blk_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            if (push_alloc) begin
                vld_q[wr_ptr_q] <= 1'b1;
                tag_q[wr_ptr_q] <= evict_tag;
                set_q[wr_ptr_q] <= evict_set;
                blk_q[wr_ptr_q] <= evict_block;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
`ifdef WB_COALESCE_EN
            if (push_req && coal_hit) begin
                blk_q[coal_idx] <= evict_block;
            end
`endif
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed checks of the write-back buffer: push/pop order, wrap, lookup, flush, async reset.
// Vectors drive inputs just after the rising edge and compare outputs on the falling edge.
// Coalescing checks are compiled only when WB_COALESCE_EN is defined.
module tb_writeback_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        evict_valid, evict_ready;
    logic [2:0]  evict_tag, evict_set;
    logic [15:0] evict_block;
    logic        mem_wr_valid, mem_wr_ready;
    logic [2:0]  mem_wr_tag, mem_wr_set;
    logic [15:0] mem_wr_block;
    logic [2:0]  lookup_tag, lookup_set;
    logic        lookup_hit;
    logic [15:0] lookup_block;
    logic        flush_req, flush_done;
    logic [2:0]  count;
    logic        full, empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_tag(evict_tag), .evict_set(evict_set), .evict_block(evict_block),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_tag(mem_wr_tag), .mem_wr_set(mem_wr_set), .mem_wr_block(mem_wr_block),
        .lookup_tag(lookup_tag), .lookup_set(lookup_set),
        .lookup_hit(lookup_hit), .lookup_block(lookup_block),
        .flush_req(flush_req), .flush_done(flush_done),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic        ev;
        logic [2:0]  tg, st;
        logic [15:0] bk;
        logic        rdy;
        logic [2:0]  lt, ls;
        logic        fl;
        logic        er, mv;
        logic [2:0]  mt, ms;
        logic [15:0] mb;
        logic        lh;
        logic [15:0] lb;
        logic [2:0]  cnt;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ev, input logic [2:0] tg, input logic [2:0] st, input logic [15:0] bk,
                       input logic rdy, input logic [2:0] lt, input logic [2:0] ls, input logic fl,
                       input logic er, input logic mv, input logic [2:0] mt, input logic [2:0] ms,
                       input logic [15:0] mb, input logic lh, input logic [15:0] lb,
                       input logic [2:0] cnt, input logic fd);
        vec_t v;
        v.ev = ev; v.tg = tg; v.st = st; v.bk = bk; v.rdy = rdy; v.lt = lt; v.ls = ls; v.fl = fl;
        v.er = er; v.mv = mv; v.mt = mt; v.ms = ms; v.mb = mb; v.lh = lh; v.lb = lb;
        v.cnt = cnt; v.fd = fd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ev, input logic [2:0] tg, input logic [2:0] st, input logic [15:0] bk,
                         input logic rdy, input logic [2:0] lt, input logic [2:0] ls, input logic fl);
        evict_valid = ev; evict_tag = tg; evict_set = st; evict_block = bk;
        mem_wr_ready = rdy; lookup_tag = lt; lookup_set = ls; flush_req = fl;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Expected packing: er,mv,mt,ms,mb,lh,lb,cnt,full,empty,fd (head fields ignored when no head is expected)
    function automatic logic [63:0] pack_exp(input vec_t v);
        return {17'd0, v.er, v.mv, v.mv ? v.mt : 3'd0, v.mv ? v.ms : 3'd0, v.mv ? v.mb : 16'd0,
                v.lh, v.lb, v.cnt, (v.cnt == 3'd4), (v.cnt == 3'd0), v.fd};
    endfunction

    function automatic logic [63:0] pack_act(input logic want_head);
        return {17'd0, evict_ready, mem_wr_valid,
                want_head ? mem_wr_tag : 3'd0, want_head ? mem_wr_set : 3'd0,
                want_head ? mem_wr_block : 16'd0,
                lookup_hit, lookup_block, count, full, empty, flush_done};
    endfunction

    initial begin
        // Test 1: single push with stalled memory, then pop
        add(1,3,0,16'hA55A, 0,3,0,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        add(0,0,0,16'h0,    0,3,0,0, 1,1,3,0,16'hA55A,    1,16'hA55A, 1,0);
        add(0,0,0,16'h0,    1,3,0,0, 1,1,3,0,16'hA55A,    1,16'hA55A, 1,0);
        add(0,0,0,16'h0,    0,3,0,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        // Test 2: fill to full, extra eviction refused, drain in order, wrap pointers
        add(1,1,1,16'h0001, 0,1,1,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        add(1,2,2,16'h0002, 0,1,1,0, 1,1,1,1,16'h0001,    1,16'h0001, 1,0);
        add(1,3,3,16'h0003, 0,1,1,0, 1,1,1,1,16'h0001,    1,16'h0001, 2,0);
        add(1,4,4,16'h0004, 0,1,1,0, 1,1,1,1,16'h0001,    1,16'h0001, 3,0);
        add(1,5,5,16'h0005, 0,4,4,0, 0,1,1,1,16'h0001,    1,16'h0004, 4,0);
        add(1,5,5,16'h0005, 1,5,5,0, 0,1,1,1,16'h0001,    0,16'h0,    4,0);
        add(0,0,0,16'h0,    1,5,5,0, 1,1,2,2,16'h0002,    0,16'h0,    3,0);
        add(0,0,0,16'h0,    1,5,5,0, 1,1,3,3,16'h0003,    0,16'h0,    2,0);
        add(1,6,6,16'h0006, 1,5,5,0, 1,1,4,4,16'h0004,    0,16'h0,    1,0);
        add(1,7,7,16'h0007, 0,5,5,0, 1,1,6,6,16'h0006,    0,16'h0,    1,0);
        add(0,0,0,16'h0,    1,6,6,0, 1,1,6,6,16'h0006,    1,16'h0006, 2,0);
        add(0,0,0,16'h0,    1,7,7,0, 1,1,7,7,16'h0007,    1,16'h0007, 1,0);
        add(0,0,0,16'h0,    0,7,7,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        // Test 3: duplicate tag/set, younger wins lookup, miss returns zero
        add(1,2,5,16'h1111, 0,2,5,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        add(1,2,5,16'h2222, 0,2,5,0, 1,1,2,5,16'h1111,    1,16'h1111, 1,0);
        add(0,0,0,16'h0,    0,2,5,0, 1,1,2,5,16'h1111,    1,16'h2222, 2,0);
        add(0,0,0,16'h0,    0,4,5,0, 1,1,2,5,16'h1111,    0,16'h0,    2,0);
        add(0,0,0,16'h0,    1,2,5,0, 1,1,2,5,16'h1111,    1,16'h2222, 2,0);
        add(0,0,0,16'h0,    1,2,5,0, 1,1,2,5,16'h2222,    1,16'h2222, 1,0);
        add(0,0,0,16'h0,    0,2,5,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        // Test 4: flush with three entries and toggling ready
        add(1,1,2,16'hC001, 0,0,0,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        add(1,1,3,16'hC002, 0,0,0,0, 1,1,1,2,16'hC001,    0,16'h0,    1,0);
        add(1,1,4,16'hC003, 0,0,0,0, 1,1,1,2,16'hC001,    0,16'h0,    2,0);
        add(0,0,0,16'h0,    0,0,0,1, 1,1,1,2,16'hC001,    0,16'h0,    3,0);
        add(1,5,5,16'h5555, 1,0,0,0, 0,1,1,2,16'hC001,    0,16'h0,    3,0);
        add(1,5,5,16'h5555, 0,0,0,0, 0,1,1,3,16'hC002,    0,16'h0,    2,0);
        add(1,5,5,16'h5555, 1,0,0,0, 0,1,1,3,16'hC002,    0,16'h0,    2,0);
        add(1,5,5,16'h5555, 0,0,0,0, 0,1,1,4,16'hC003,    0,16'h0,    1,0);
        add(1,5,5,16'h5555, 1,0,0,0, 0,1,1,4,16'hC003,    0,16'h0,    1,0);
        add(1,5,5,16'h5555, 1,0,0,0, 0,0,0,0,16'h0,       0,16'h0,    0,1);
        add(0,0,0,16'h0,    0,0,0,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        // Flush on an empty buffer: done pulses two cycles after the request; repeat request ignored
        add(0,0,0,16'h0,    0,0,0,1, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        add(0,0,0,16'h0,    0,0,0,1, 0,0,0,0,16'h0,       0,16'h0,    0,0);
        add(0,0,0,16'h0,    0,0,0,0, 0,0,0,0,16'h0,       0,16'h0,    0,1);
        add(0,0,0,16'h0,    0,0,0,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);
        add(0,0,0,16'h0,    0,0,0,0, 1,0,0,0,16'h0,       0,16'h0,    0,0);

        rst_n = 1'b0;
        drive(0,0,0,16'h0, 0,0,0,0);
        repeat (2) @(negedge clk);
        // Reset state: empty, nothing presented, no hit, no done
        chk("reset_state", pack_act(1'b0), {17'd0, 1'b1, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].ev, vecs[i].tg, vecs[i].st, vecs[i].bk,
                  vecs[i].rdy, vecs[i].lt, vecs[i].ls, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d", i), pack_act(vecs[i].mv), pack_exp(vecs[i]));
        end

        // Test 5: asynchronous reset mid-cycle with three entries and a stalled write
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            drive(1, 3'd5, 3'(i), 16'h0500 + 16'(i), 0, 3'd5, 3'd1, 0);
        end
        @(posedge clk); #1;
        drive(0,0,0,16'h0, 0,5,1,0);
        @(negedge clk);
        chk("pre_reset_count", {61'd0, count}, 64'd3);
        chk("pre_reset_hit", {63'd0, lookup_hit}, 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mv", {63'd0, mem_wr_valid}, 64'd0);
        chk("async_rst_count", {61'd0, count}, 64'd0);
        chk("async_rst_empty", {63'd0, empty}, 64'd1);
        chk("async_rst_hit", {63'd0, lookup_hit}, 64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 3'd6, 3'd1, 16'hABCD, 0, 3'd5, 3'd2, 0);
        @(posedge clk); #1;
        drive(0,0,0,16'h0, 0,5,2,0);
        @(negedge clk);
        chk("post_rst_head", {27'd0, mem_wr_valid, mem_wr_tag, mem_wr_set, mem_wr_block, count},
            {27'd0, 1'b1, 3'd6, 3'd1, 16'hABCD, 3'd1});
        chk("post_rst_stale_hit", {63'd0, lookup_hit}, 64'd0);
        @(posedge clk); #1;
        drive(0,0,0,16'h0, 1,0,0,0);
        @(negedge clk);
        chk("post_rst_head_stable", {45'd0, mem_wr_tag, mem_wr_block}, {45'd0, 3'd6, 16'hABCD});

`ifdef WB_COALESCE_EN
        // Test 6: coalesce into a non-head entry while full
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            drive(1, 3'(i), 3'(i), 16'(i), 0, 3'd3, 3'd3, 0);
        end
        @(posedge clk); #1;
        drive(1, 3'd3, 3'd3, 16'hBEEF, 0, 3'd3, 3'd3, 0);
        @(negedge clk);
        chk("coal_full", {63'd0, full}, 64'd1);
        chk("coal_ready", {63'd0, evict_ready}, 64'd1);
        @(posedge clk); #1;
        drive(1, 3'd1, 3'd1, 16'h7777, 0, 3'd3, 3'd3, 0);
        @(negedge clk);
        chk("coal_count", {61'd0, count}, 64'd4);
        chk("coal_lookup", {47'd0, lookup_hit, lookup_block}, {47'd0, 1'b1, 16'hBEEF});
        chk("coal_head", {45'd0, mem_wr_tag, mem_wr_block}, {45'd0, 3'd1, 16'h0001});
        chk("coal_head_match_refused", {63'd0, evict_ready}, 64'd0);
`endif

        @(posedge clk); #1;
        drive(0,0,0,16'h0, 0,0,0,0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
